// File: rtl/bus_ctrl_wdog_pkg.sv
// Shared types and helpers for the per-CPU bus transaction watchdog.
package bus_ctrl_wdog_pkg;

    // Per-channel transaction tracking state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        EXPIRED = 2'd2
    } wdog_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int cpu_idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/bus_ctrl_wdog_chan.sv
// One watchdog channel: times a single CPU's requests, flags timeouts and
// dropped requests, and keeps the worst completed latency.
module bus_ctrl_wdog_chan
    import bus_ctrl_wdog_pkg::*;
#(
    parameter int TIMEOUT = 50,
    parameter int LAT_W   = 16,
    parameter bit STICKY  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req,
    input  logic             done,
    input  logic             clear,
    output logic             timeout_evt,
    output logic             timeout_err,
    output logic             proto_err,
    output logic [LAT_W-1:0] max_lat
);

    localparam logic [LAT_W:0]   TIMEOUT_W = (LAT_W + 1)'(TIMEOUT);
    localparam logic [LAT_W:0]   ONE_W     = {{LAT_W{1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};

    wdog_state_e      state_r;
    wdog_state_e      state_nxt_s;
    logic [LAT_W-1:0] cnt_r;
    logic [LAT_W-1:0] cnt_nxt_s;
    logic             done_s;
    logic [LAT_W:0]   lat_wide_s;
    logic [LAT_W-1:0] lat_sat_s;
    logic             expire_s;
    logic             complete_s;
    logic             timeout_evt_s;
    logic             proto_evt_s;

    // done only means something while the request is still pending
    assign done_s     = req & done;
    // cnt is zero in IDLE, so cnt+1 is the age of the current cycle in every live state
    assign lat_wide_s = {1'b0, cnt_r} + ONE_W;
    assign lat_sat_s  = lat_wide_s[LAT_W] ? LAT_MAX : lat_wide_s[LAT_W-1:0];
    assign expire_s   = (lat_wide_s == TIMEOUT_W);
    assign timeout_evt = timeout_evt_s;

    // State and cycle-count registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, WAIT: begin
                if (done_s || !req) begin
                    state_nxt_s = IDLE;
                end else if (expire_s) begin
                    state_nxt_s = EXPIRED;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            EXPIRED: begin
                if (done_s || !req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = EXPIRED;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-cycle events and next count derived from the current state.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        complete_s    = 1'b0;
        timeout_evt_s = 1'b0;
        proto_evt_s   = 1'b0;
        case (state_r)
            IDLE, WAIT: begin
                if (done_s) begin
                    complete_s = 1'b1;
                    cnt_nxt_s  = '0;
                end else if (req) begin
                    cnt_nxt_s     = lat_wide_s[LAT_W-1:0];
                    timeout_evt_s = expire_s;
                end else begin
                    cnt_nxt_s   = '0;
                    proto_evt_s = (state_r == WAIT);
                end
            end
            EXPIRED: begin
                if (done_s || !req) begin
                    cnt_nxt_s = '0;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: cnt_nxt_s = '0;
        endcase
    end

    // Error flags: sticky until clear, or single-cycle pulses; a new event beats clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            timeout_err <= timeout_evt_s | (STICKY & timeout_err & ~clear);
            proto_err   <= proto_evt_s   | (STICKY & proto_err   & ~clear);
        end
    end

    // Worst completed latency; a completion coinciding with clear restarts from its own value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            max_lat <= '0;
        end else if (complete_s) begin
            max_lat <= (clear || (lat_sat_s > max_lat)) ? lat_sat_s : max_lat;
        end else if (clear) begin
            max_lat <= '0;
        end else begin
            max_lat <= max_lat;
        end
    end

endmodule

// File: rtl/bus_ctrl_watchdog.sv
// Observe-only per-CPU transaction watchdog for the coherence bus controller.
module bus_ctrl_watchdog
    import bus_ctrl_wdog_pkg::*;
#(
    parameter int NUM_CPUS = 2,
    parameter int TIMEOUT  = 50,
    parameter int LAT_W    = 16,
    parameter bit STICKY   = 1'b1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NUM_CPUS-1:0]                  req,
    input  logic [NUM_CPUS-1:0]                  done,
    input  logic                                 clear,
    output logic [NUM_CPUS-1:0]                  timeout_err,
    output logic [NUM_CPUS-1:0]                  proto_err,
    output logic                                 any_err,
    output logic                                 first_err_valid,
    output logic [cpu_idx_width(NUM_CPUS)-1:0]   first_err_cpu,
    output logic [NUM_CPUS*LAT_W-1:0]            max_lat
);

    localparam int CPU_W = cpu_idx_width(NUM_CPUS);

    logic [NUM_CPUS-1:0] timeout_evt_s;
    logic [NUM_CPUS-1:0] clear_s;
    logic [CPU_W-1:0]    first_idx_s;
    logic                any_evt_s;

    assign clear_s   = {NUM_CPUS{clear}};
    assign any_evt_s = |timeout_evt_s;
    assign any_err   = (|timeout_err) | (|proto_err);

    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_chan
        bus_ctrl_wdog_chan #(
            .TIMEOUT (TIMEOUT),
            .LAT_W   (LAT_W),
            .STICKY  (STICKY)
        ) u_chan (
            .CLK         (CLK),
            .RST         (RST),
            .req         (req[g]),
            .done        (done[g]),
            .clear       (clear_s[g]),
            .timeout_evt (timeout_evt_s[g]),
            .timeout_err (timeout_err[g]),
            .proto_err   (proto_err[g]),
            .max_lat     (max_lat[g*LAT_W +: LAT_W])
        );
    end

    // Lowest-index channel expiring this cycle (scan high to low so low wins).
    always_comb begin
        first_idx_s = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            first_idx_s = timeout_evt_s[i] ? CPU_W'(i) : first_idx_s;
        end
    end

    // First-timeout capture, held until clear; an expiry in the clear cycle is captured.
    always_ff @(posedge CLK) begin
        if (RST) begin
            first_err_valid <= 1'b0;
            first_err_cpu   <= '0;
        end else if (any_evt_s && (!first_err_valid || clear)) begin
            first_err_valid <= 1'b1;
            first_err_cpu   <= first_idx_s;
        end else if (clear) begin
            first_err_valid <= 1'b0;
            first_err_cpu   <= '0;
        end else begin
            first_err_valid <= first_err_valid;
            first_err_cpu   <= first_err_cpu;
        end
    end

endmodule
